// File: rtl/uart_depacketizer.sv
// UART 8N1 receiver feeding a framing FSM: 0xA5, LEN, payload[, checksum].
// Define UART_DEPACKETIZER_CHECKSUM_EN to require a trailing XOR checksum byte.
module uart_depacketizer #(
   parameter int unsigned CLKS_PER_BIT = 16,
   parameter int unsigned MAX_LEN      = 16,
   parameter int unsigned TIMEOUT_BITS = 20
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       serial_in,
   output logic [7:0] data_out,
   output logic       data_valid,
   output logic       sop,
   output logic       eop,
   output logic       pkt_ok,
   output logic       pkt_err,
   output logic       rx_busy
);

   localparam int unsigned CntW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
   localparam logic [CntW-1:0] BitLast  = CntW'(CLKS_PER_BIT - 1);
   localparam logic [CntW-1:0] HalfLast = CntW'(CLKS_PER_BIT / 2 - 1);
   localparam int unsigned ToCycles = TIMEOUT_BITS * CLKS_PER_BIT;
   localparam int unsigned ToW      = $clog2(ToCycles + 1);
   localparam logic [ToW-1:0] ToLast = ToW'(ToCycles - 1);
   localparam logic [7:0] MaxLen = 8'(MAX_LEN);

   typedef enum logic [1:0] {RxIdle, RxStart, RxData, RxStop} rx_state_e;
`ifdef UART_DEPACKETIZER_CHECKSUM_EN
   typedef enum logic [1:0] {PkIdle, PkLen, PkPayload, PkChk} pk_state_e;
`else
   typedef enum logic [1:0] {PkIdle, PkLen, PkPayload} pk_state_e;
`endif

   logic            r_sync1, r_sync2, r_sync3;
   rx_state_e       r_rx_state;
   logic [CntW-1:0] r_clk_cnt;
   logic [2:0]      r_bit_idx;
   logic [7:0]      r_shift;
   logic            r_rx_busy;
   logic            r_rx_done;
   logic            r_rx_ferr;

   pk_state_e       r_pk_state;
   logic [7:0]      r_len;
   logic [7:0]      r_pay_cnt;
   logic [ToW-1:0]  r_to_cnt;
`ifdef UART_DEPACKETIZER_CHECKSUM_EN
   logic [7:0]      r_chk;
`endif
   logic [7:0]      r_data_out;
   logic            r_data_valid, r_sop, r_eop, r_pkt_ok, r_pkt_err;

   logic w_fall;
   logic w_last;

   assign w_fall = r_sync3 & ~r_sync2;
   assign w_last = (r_pay_cnt == (r_len - 8'd1));

   assign data_out   = r_data_out;
   assign data_valid = r_data_valid;
   assign sop        = r_sop;
   assign eop        = r_eop;
   assign pkt_ok     = r_pkt_ok;
   assign pkt_err    = r_pkt_err;
   assign rx_busy    = r_rx_busy;

   // r_sync3 only holds the previous synchronized level for edge detection.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_sync1 <= 1'b1;
         r_sync2 <= 1'b1;
         r_sync3 <= 1'b1;
      end else begin
         r_sync1 <= serial_in;
         r_sync2 <= r_sync1;
         r_sync3 <= r_sync2;
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_rx_state <= RxIdle;
         r_clk_cnt  <= '0;
         r_bit_idx  <= '0;
         r_shift    <= '0;
         r_rx_busy  <= 1'b0;
         r_rx_done  <= 1'b0;
         r_rx_ferr  <= 1'b0;
      end else begin
         r_rx_done <= 1'b0;
         r_rx_ferr <= 1'b0;
         case (r_rx_state)
            RxIdle: begin
               if (w_fall) begin
                  r_rx_state <= RxStart;
                  r_clk_cnt  <= '0;
                  r_rx_busy  <= 1'b1;
               end
            end
            RxStart: begin
               if (r_clk_cnt == HalfLast) begin
                  r_clk_cnt <= '0;
                  r_bit_idx <= '0;
                  // Line back high at mid start bit: glitch, not a byte.
                  if (r_sync2) begin
                     r_rx_state <= RxIdle;
                     r_rx_busy  <= 1'b0;
                  end else begin
                     r_rx_state <= RxData;
                  end
               end else begin
                  r_clk_cnt <= r_clk_cnt + 1'b1;
               end
            end
            RxData: begin
               if (r_clk_cnt == BitLast) begin
                  r_clk_cnt <= '0;
                  r_shift   <= {r_sync2, r_shift[7:1]};
                  if (r_bit_idx == 3'd7) begin
                     r_rx_state <= RxStop;
                  end else begin
                     r_bit_idx <= r_bit_idx + 3'd1;
                  end
               end else begin
                  r_clk_cnt <= r_clk_cnt + 1'b1;
               end
            end
            RxStop: begin
               if (r_clk_cnt == BitLast) begin
                  r_clk_cnt  <= '0;
                  r_rx_state <= RxIdle;
                  r_rx_busy  <= 1'b0;
                  r_rx_done  <= r_sync2;
                  r_rx_ferr  <= ~r_sync2;
               end else begin
                  r_clk_cnt <= r_clk_cnt + 1'b1;
               end
            end
            default: begin
               r_rx_state <= RxIdle;
               r_rx_busy  <= 1'b0;
            end
         endcase
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_pk_state   <= PkIdle;
         r_len        <= '0;
         r_pay_cnt    <= '0;
         r_to_cnt     <= '0;
`ifdef UART_DEPACKETIZER_CHECKSUM_EN
         r_chk        <= '0;
`endif
         r_data_out   <= '0;
         r_data_valid <= 1'b0;
         r_sop        <= 1'b0;
         r_eop        <= 1'b0;
         r_pkt_ok     <= 1'b0;
         r_pkt_err    <= 1'b0;
      end else begin
         r_data_valid <= 1'b0;
         r_sop        <= 1'b0;
         r_eop        <= 1'b0;
         r_pkt_ok     <= 1'b0;
         r_pkt_err    <= 1'b0;

         // Inter-byte idle timer runs only while a packet is open and the line is quiet.
         if (r_pk_state == PkIdle || r_rx_busy || r_rx_done || r_rx_ferr) begin
            r_to_cnt <= '0;
         end else begin
            r_to_cnt <= r_to_cnt + 1'b1;
         end

         if (r_rx_ferr) begin
            if (r_pk_state != PkIdle) begin
               r_pkt_err  <= 1'b1;
               r_pk_state <= PkIdle;
            end
         end else if (r_rx_done) begin
            case (r_pk_state)
               PkIdle: begin
                  if (r_shift == 8'hA5) begin
                     r_pk_state <= PkLen;
                  end
               end
               PkLen: begin
                  if (r_shift != 8'd0 && r_shift <= MaxLen) begin
                     r_len      <= r_shift;
                     r_pay_cnt  <= '0;
`ifdef UART_DEPACKETIZER_CHECKSUM_EN
                     r_chk      <= r_shift;
`endif
                     r_pk_state <= PkPayload;
                  end else begin
                     r_pkt_err  <= 1'b1;
                     r_pk_state <= PkIdle;
                  end
               end
               PkPayload: begin
                  r_data_out   <= r_shift;
                  r_data_valid <= 1'b1;
                  r_sop        <= (r_pay_cnt == 8'd0);
                  r_eop        <= w_last;
                  r_pay_cnt    <= r_pay_cnt + 8'd1;
`ifdef UART_DEPACKETIZER_CHECKSUM_EN
                  r_chk        <= r_chk ^ r_shift;
                  if (w_last) begin
                     r_pk_state <= PkChk;
                  end
`else
                  if (w_last) begin
                     r_pkt_ok   <= 1'b1;
                     r_pk_state <= PkIdle;
                  end
`endif
               end
`ifdef UART_DEPACKETIZER_CHECKSUM_EN
               PkChk: begin
                  r_pkt_ok   <= (r_shift == r_chk);
                  r_pkt_err  <= (r_shift != r_chk);
                  r_pk_state <= PkIdle;
               end
`endif
               default: r_pk_state <= PkIdle;
            endcase
         end else if (r_pk_state != PkIdle && !r_rx_busy && r_to_cnt == ToLast) begin
            r_pkt_err  <= 1'b1;
            r_pk_state <= PkIdle;
         end
      end
   end

endmodule

// File: tb/tb_uart_depacketizer.sv
// Directed bench for uart_depacketizer; expectations follow UART_DEPACKETIZER_CHECKSUM_EN.
module tb_uart_depacketizer;

   localparam int unsigned Cpb = 16;

`ifdef UART_DEPACKETIZER_CHECKSUM_EN
   localparam int unsigned Ck = 1;
`else
   localparam int unsigned Ck = 0;
`endif

   logic       clk = 1'b0;
   logic       rst = 1'b0;
   logic       serial_in = 1'b1;
   logic [7:0] data_out;
   logic       data_valid, sop, eop, pkt_ok, pkt_err, rx_busy;

   always #5 clk = ~clk;

   uart_depacketizer #(
      .CLKS_PER_BIT(Cpb),
      .MAX_LEN     (16),
      .TIMEOUT_BITS(20)
   ) dut (
      .clk       (clk),
      .rst       (rst),
      .serial_in (serial_in),
      .data_out  (data_out),
      .data_valid(data_valid),
      .sop       (sop),
      .eop       (eop),
      .pkt_ok    (pkt_ok),
      .pkt_err   (pkt_err),
      .rx_busy   (rx_busy)
   );

   int unsigned n_cmp, n_mis;
   int unsigned n_valid, n_sop, n_eop, n_ok, n_err, n_both, n_ok_eop, n_sop_eop, n_busy;
   logic [7:0]  sop_byte, eop_byte;
   logic [7:0]  rx_q[$];
   logic [7:0]  tx_q[$];
   int unsigned b_valid, b_sop, b_eop, b_ok, b_err, b_ok_eop, b_sop_eop, b_busy, b_q;

   always @(negedge clk) begin
      if (data_valid) begin
         n_valid <= n_valid + 1;
         rx_q.push_back(data_out);
      end
      if (sop) begin
         n_sop    <= n_sop + 1;
         sop_byte <= data_out;
      end
      if (eop) begin
         n_eop    <= n_eop + 1;
         eop_byte <= data_out;
      end
      if (data_valid && sop && eop) n_sop_eop <= n_sop_eop + 1;
      if (pkt_ok) n_ok <= n_ok + 1;
      if (pkt_err) n_err <= n_err + 1;
      if (pkt_ok && pkt_err) n_both <= n_both + 1;
      if (pkt_ok && eop && data_valid) n_ok_eop <= n_ok_eop + 1;
      if (rx_busy) n_busy <= n_busy + 1;
   end

   task automatic check_val(input string tag, input int unsigned got, input int unsigned exp);
      n_cmp++;
      if (got !== exp) begin
         n_mis++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
      end
   endtask

   task automatic snap();
      b_valid   = n_valid;
      b_sop     = n_sop;
      b_eop     = n_eop;
      b_ok      = n_ok;
      b_err     = n_err;
      b_ok_eop  = n_ok_eop;
      b_sop_eop = n_sop_eop;
      b_busy    = n_busy;
      b_q       = rx_q.size();
   endtask

   task automatic idle(input int unsigned cycles);
      repeat (cycles) @(negedge clk);
   endtask

   task automatic send_byte(input logic [7:0] b, input logic stop);
      serial_in = 1'b0;
      idle(Cpb);
      for (int i = 0; i < 8; i++) begin
         serial_in = b[i];
         idle(Cpb);
      end
      serial_in = stop;
      idle(Cpb);
      serial_in = 1'b1;
   endtask

   task automatic send_q();
      foreach (tx_q[i]) send_byte(tx_q[i], 1'b1);
      tx_q.delete();
      idle(40);
   endtask

   function automatic int unsigned q_at(input int unsigned idx);
      if (idx < rx_q.size()) return int'(rx_q[idx]);
      return 32'hDEAD;
   endfunction

   initial begin
      logic [7:0] xs;

      // Reset
      idle(3);
      check_val("reset_outputs", {data_out, data_valid, sop, eop, pkt_ok, pkt_err, rx_busy}, 0);
      rst = 1'b1;
      idle(20);

      // Good packet
      snap();
      tx_q = {8'hA5, 8'h03, 8'h11, 8'h22, 8'h33, 8'h03};
      send_q();
      check_val("good_valid_cnt", n_valid - b_valid, 3);
      check_val("good_byte0", q_at(b_q), 8'h11);
      check_val("good_byte1", q_at(b_q + 1), 8'h22);
      check_val("good_byte2", q_at(b_q + 2), 8'h33);
      check_val("good_sop_cnt", n_sop - b_sop, 1);
      check_val("good_sop_byte", sop_byte, 8'h11);
      check_val("good_eop_cnt", n_eop - b_eop, 1);
      check_val("good_eop_byte", eop_byte, 8'h33);
      check_val("good_ok", n_ok - b_ok, 1);
      check_val("good_err", n_err - b_err, 0);
      check_val("good_ok_with_eop", n_ok_eop - b_ok_eop, (Ck != 0) ? 0 : 1);

      // Bad checksum
      snap();
      tx_q = {8'hA5, 8'h03, 8'h11, 8'h22, 8'h33, 8'h04};
      send_q();
      check_val("badck_valid_cnt", n_valid - b_valid, 3);
      check_val("badck_ok", n_ok - b_ok, (Ck != 0) ? 0 : 1);
      check_val("badck_err", n_err - b_err, (Ck != 0) ? 1 : 0);

      // Junk before sync, then single-byte packet
      snap();
      tx_q = {8'h00, 8'h5A};
      send_q();
      check_val("junk_quiet", (n_valid - b_valid) + (n_ok - b_ok) + (n_err - b_err), 0);
      snap();
      tx_q = {8'hA5, 8'h01, 8'h7E, 8'h7F};
      send_q();
      check_val("one_valid_cnt", n_valid - b_valid, 1);
      check_val("one_byte", q_at(b_q), 8'h7E);
      check_val("one_sop_eop", n_sop_eop - b_sop_eop, 1);
      check_val("one_ok", n_ok - b_ok, 1);

      // Illegal lengths
      snap();
      tx_q = {8'hA5, 8'h00};
      send_q();
      check_val("len0_err", n_err - b_err, 1);
      check_val("len0_valid", n_valid - b_valid, 0);
      snap();
      tx_q = {8'hA5, 8'h11};
      send_q();
      check_val("len17_err", n_err - b_err, 1);
      check_val("len17_valid", n_valid - b_valid, 0);
      snap();
      tx_q = {8'hA5, 8'h01, 8'h7E, 8'h7F};
      send_q();
      check_val("after_len_ok", n_ok - b_ok, 1);
      check_val("after_len_err", n_err - b_err, 0);

      // Maximum length packet
      snap();
      xs = 8'h10;
      tx_q = {8'hA5, 8'h10};
      for (int i = 1; i <= 16; i++) begin
         tx_q.push_back(8'(i));
         xs = xs ^ 8'(i);
      end
      tx_q.push_back(xs);
      send_q();
      check_val("max_valid_cnt", n_valid - b_valid, 16);
      check_val("max_eop_byte", eop_byte, 8'h10);
      check_val("max_ok", n_ok - b_ok, 1);

      // Framing error on payload byte
      snap();
      send_byte(8'hA5, 1'b1);
      send_byte(8'h02, 1'b1);
      send_byte(8'hAA, 1'b0);
      idle(40);
      check_val("ferr_valid", n_valid - b_valid, 0);
      check_val("ferr_err", n_err - b_err, 1);
      check_val("ferr_ok", n_ok - b_ok, 0);

      // Short glitch on idle line
      snap();
      serial_in = 1'b0;
      idle(4);
      serial_in = 1'b1;
      idle(40);
      check_val("glitch_busy_seen", ((n_busy - b_busy) > 0) ? 1 : 0, 1);
      check_val("glitch_busy_short", ((n_busy - b_busy) <= 8) ? 1 : 0, 1);
      check_val("glitch_quiet", (n_valid - b_valid) + (n_ok - b_ok) + (n_err - b_err), 0);

      // Inter-byte timeout
      snap();
      send_byte(8'hA5, 1'b1);
      send_byte(8'h02, 1'b1);
      send_byte(8'h11, 1'b1);
      idle(200);
      check_val("to_not_yet", n_err - b_err, 0);
      idle(200);
      check_val("to_err", n_err - b_err, 1);
      check_val("to_kept_byte", n_valid - b_valid, 1);

      // Reset in the middle of payload byte 2
      snap();
      send_byte(8'hA5, 1'b1);
      send_byte(8'h03, 1'b1);
      send_byte(8'h11, 1'b1);
      serial_in = 1'b0;
      idle(Cpb * 4);
      check_val("mid_busy_before_rst", rx_busy, 1);
      rst = 1'b0;
      #1;
      check_val("rst_outputs", {data_out, data_valid, sop, eop, pkt_ok, pkt_err, rx_busy}, 0);
      serial_in = 1'b1;
      idle(10);
      rst = 1'b1;
      idle(40);
      check_val("rst_no_err", n_err - b_err, 0);
      snap();
      tx_q = {8'h22, 8'h33};
      send_q();
      check_val("rst_no_resume", n_valid - b_valid, 0);
      snap();
      tx_q = {8'hA5, 8'h01, 8'h7E, 8'h7F};
      send_q();
      check_val("rst_new_pkt_ok", n_ok - b_ok, 1);

      check_val("ok_err_exclusive", n_both, 0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
      $finish;
   end

endmodule

// File: doc/uart_depacketizer.md
UART_DEPACKETIZER -- requirements
Module: uart_depacketizer

Interface
REQ-001 SHALL have parameter CLKS_PER_BIT, default 16: clk cycles per UART bit; it SHALL match the transmitter setting.
REQ-002 SHALL have parameter MAX_LEN, default 16: largest accepted payload length in bytes (1..255).
REQ-003 SHALL have parameter TIMEOUT_BITS, default 20: idle bit-times allowed between bytes inside a packet.
REQ-004 SHALL have port clk  input  1  single clock; all logic on its rising edge.
REQ-005 SHALL have port rst  input  1  asynchronous, active-low reset.
REQ-006 SHALL have port serial_in  input  1  UART line, idle high, 8N1, LSB first.
REQ-007 SHALL have port data_out  output  8  payload byte; valid only while data_valid=1.
REQ-008 SHALL have port data_valid  output  1  one-cycle strobe per payload byte.
REQ-009 SHALL have port sop  output  1  asserted with data_valid on the first payload byte.
REQ-010 SHALL have port eop  output  1  asserted with data_valid on the last payload byte.
REQ-011 SHALL have port pkt_ok  output  1  one-cycle pulse when a packet completes without error.
REQ-012 SHALL have port pkt_err  output  1  one-cycle pulse when a packet is aborted.
REQ-013 SHALL have port rx_busy  output  1  high from start-bit detection to stop-bit sample.

Function
REQ-014 SHALL pass serial_in through a 2-flop synchronizer before any use.
REQ-015 SHALL detect a start bit on a synchronized 1->0 edge and re-check the line at CLKS_PER_BIT/2; if the line is high there, the start SHALL be treated as a glitch and no byte produced.
REQ-016 SHALL sample the 8 data bits and the stop bit at the middle of each bit, CLKS_PER_BIT cycles apart.
REQ-017 SHALL deliver the received byte to the packet FSM one cycle after the stop-bit sample.
REQ-018 SHALL treat a stop bit sampled as 0 as a framing error: drop the byte; if the FSM is outside IDLE, pulse pkt_err and return to IDLE.
REQ-019 SHALL implement packet FSM states IDLE, LEN, PAYLOAD, CHK.
REQ-020 In IDLE, byte 0xA5 SHALL move the FSM to LEN; every other byte SHALL be discarded silently.
REQ-021 In LEN, a length of 1..MAX_LEN SHALL be latched and move the FSM to PAYLOAD; a length of 0 or above MAX_LEN SHALL pulse pkt_err and return to IDLE.
REQ-022 In PAYLOAD, each byte SHALL drive data_out and pulse data_valid; sop SHALL mark byte 1 and eop byte LEN; a one-byte packet SHALL assert sop and eop together.
REQ-023 A running checksum SHALL hold XOR of the LEN byte and all payload bytes, and SHALL be cleared on entering LEN.
REQ-024 After byte LEN, the FSM SHALL enter CHK (CHECKSUM_EN defined) or IDLE (not defined).
REQ-025 In CHK, a received byte equal to the checksum SHALL pulse pkt_ok; any other value SHALL pulse pkt_err; both cases SHALL return to IDLE.
REQ-026 In LEN, PAYLOAD or CHK, no start bit within TIMEOUT_BITS*CLKS_PER_BIT cycles of the last stop bit SHALL pulse pkt_err and return to IDLE.
REQ-027 pkt_ok and pkt_err SHALL never both be asserted, and each SHALL pulse at most once per packet.
REQ-028 Payload bytes already emitted SHALL not be retracted on a later error; the consumer discards them on pkt_err.

Reset
REQ-029 With rst=0, all outputs SHALL be 0 and the FSM in IDLE, receiver idle, and counters and checksum cleared, regardless of clk.
REQ-030 Reset asserted mid-packet SHALL abandon the packet without a pkt_err pulse; after release, only a new 0xA5 SHALL start a packet.
REQ-031 Synchronizer flops SHALL reset to 1 (line idle).

Configuration
REQ-032 With macro UART_DEPACKETIZER_CHECKSUM_EN defined, the frame SHALL be 0xA5, LEN, payload, checksum, with pkt_ok/pkt_err decided per REQ-025.
REQ-033 Without UART_DEPACKETIZER_CHECKSUM_EN, the frame SHALL be 0xA5, LEN, payload; pkt_ok SHALL pulse in the same cycle as eop; the checksum logic and the CHK state SHALL be absent.

Verification (CLKS_PER_BIT=16, MAX_LEN=16, checksum enabled unless noted)
REQ-034 A5 03 11 22 33 03 -> data_valid x3 with 0x11/0x22/0x33, sop with 0x11, eop with 0x33, one pkt_ok, no pkt_err.
REQ-035 A5 03 11 22 33 04 -> the same three data_valid pulses, then one pkt_err, no pkt_ok.
REQ-036 00 5A then A5 01 7E 7F -> no output for 00/5A; 0x7E with sop=eop=1, then pkt_ok.
REQ-037 A5 00, and separately A5 11 -> pkt_err with no data_valid; following A5 01 7E 7F -> pkt_ok.
REQ-038 A5 02 AA with stop bit forced low -> no data_valid for 0xAA, pkt_err; a 4-cycle low glitch on idle line -> no rx_busy beyond cycle 8, no output.
REQ-039 rst low during payload byte 2 -> all outputs 0 immediately, no pkt_err; macro undefined, A5 02 01 02 -> pkt_ok coincident with eop.
